// File: rtl/pmc_dump_controller.sv
// Performance-counter dump sequencer: freezes the bank, walks every counter and writes each
// value to BASE_ADDR + 4*idx. Define PMC_DUMP_CHECKSUM_EN to append an XOR checksum word.
module pmc_dump_controller #(
    parameter int unsigned NUM_COUNTERS = 26,
    parameter int unsigned IDX_W        = 5,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
    parameter int unsigned ACK_TIMEOUT  = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic [IDX_W-1:0] cnt_sel_o,
    input  logic [31:0]      cnt_value_i,
    output logic             freeze_o,
    output logic             mem_req_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic             mem_ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o
);

    // Timer counts completed no-ack cycles; it only needs to reach ACK_TIMEOUT-1.
    localparam int unsigned     TMR_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COUNTERS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StCapture,
        StWrite,
`ifdef PMC_DUMP_CHECKSUM_EN
        StCksum,
`endif
        StDone
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [TMR_W-1:0] timer_q;
    logic             freeze_q;
    logic             mem_req_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
`ifdef PMC_DUMP_CHECKSUM_EN
    logic [31:0]      cksum_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            timer_q     <= '0;
            freeze_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef PMC_DUMP_CHECKSUM_EN
            cksum_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q  <= StSelect;
                        idx_q    <= '0;
                        error_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        freeze_q <= 1'b1;
`ifdef PMC_DUMP_CHECKSUM_EN
                        cksum_q  <= '0;
`endif
                    end
                end

                // cnt_sel already equals idx here; this cycle lets the bank mux settle.
                StSelect: begin
                    state_q <= StCapture;
                end

                StCapture: begin
                    state_q     <= StWrite;
                    timer_q     <= '0;
                    mem_req_q   <= 1'b1;
                    mem_addr_q  <= BASE_ADDR + (32'(idx_q) << 2);
                    mem_wdata_q <= cnt_value_i;
`ifdef PMC_DUMP_CHECKSUM_EN
                    cksum_q     <= cksum_q ^ cnt_value_i;
`endif
                end

                StWrite: begin
                    if (mem_ack_i) begin
                        if (idx_q == LAST_IDX) begin
`ifdef PMC_DUMP_CHECKSUM_EN
                            state_q     <= StCksum;
                            timer_q     <= '0;
                            mem_addr_q  <= BASE_ADDR + (32'(NUM_COUNTERS) << 2);
                            mem_wdata_q <= cksum_q;
`else
                            state_q   <= StDone;
                            mem_req_q <= 1'b0;
                            done_q    <= 1'b1;
`endif
                        end else begin
                            state_q   <= StSelect;
                            mem_req_q <= 1'b0;
                            idx_q     <= idx_q + IDX_W'(1);
                        end
                    end else if (timer_q == TMR_LAST) begin
                        state_q   <= StDone;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        error_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end

`ifdef PMC_DUMP_CHECKSUM_EN
                StCksum: begin
                    if (mem_ack_i) begin
                        state_q   <= StDone;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (timer_q == TMR_LAST) begin
                        state_q   <= StDone;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        error_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
`endif

                StDone: begin
                    state_q  <= StIdle;
                    busy_q   <= 1'b0;
                    freeze_q <= 1'b0;
                end

                default: begin
                    state_q   <= StIdle;
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    freeze_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_sel_o   = idx_q;
    assign freeze_o    = freeze_q;
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_pmc_dump_controller.sv
// Directed bench for pmc_dump_controller: reset, full dump, ack stall, timeout abort,
// start re-pulse and (with PMC_DUMP_CHECKSUM_EN) the checksum word.
module tb_pmc_dump_controller;

`ifdef PMC_DUMP_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int DONE_LAT = 79 + CK;
    localparam int N_WRITES = 26 + CK;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  cnt_sel;
    logic [31:0] cnt_value;
    logic        freeze;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic        error;

    logic [31:0] bank [32];
    assign cnt_value = bank[cnt_sel];

    pmc_dump_controller dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .cnt_sel_o   (cnt_sel),
        .cnt_value_i (cnt_value),
        .freeze_o    (freeze),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ack_i   (mem_ack),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Negedge monitor: cycle count, handshakes, freeze cycles, done pulses, stall hold.
    int          ncyc = 0;
    int          wcnt = 0;
    int          frz_cnt = 0;
    int          done_cnt = 0;
    int          hold_cnt = 0;
    logic [31:0] w_addr [64];
    logic [31:0] w_data [64];

    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (mem_req && mem_ack) begin
            if (wcnt < 64) begin
                w_addr[wcnt] <= mem_addr;
                w_data[wcnt] <= mem_wdata;
            end
            wcnt <= wcnt + 1;
        end
        if (freeze) frz_cnt <= frz_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (mem_req && mem_addr == 32'h414 && mem_wdata == 32'h50) hold_cnt <= hold_cnt + 1;
    end

    // Ack driver: 0 = never ack, 1 = tied high, 2 = stall idx 5 for three cycles.
    int ack_mode = 1;
    int req_age  = 0;
    initial begin
        mem_ack = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) req_age = req_age + 1;
            else req_age = 0;
            case (ack_mode)
                0:       mem_ack = 1'b0;
                1:       mem_ack = 1'b1;
                default: mem_ack = !(mem_addr == 32'h414 && req_age <= 3);
            endcase
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    int start_cyc;
    int w_base, f_base, d_base, h_base;

    task automatic snap();
        w_base = wcnt;
        f_base = frz_cnt;
        d_base = done_cnt;
        h_base = hold_cnt;
    endtask

    task automatic pulse_start();
        start     = 1'b1;
        start_cyc = ncyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (!done && n < max_cyc) begin
            step();
            n++;
        end
        check_val("done_seen", 32'(done), 32'd1);
    endtask

    logic [31:0] ck_exp;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = 32'(i * 16);
        start = 1'b0;
        rst_n = 1'b0;
        step();
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_mem_req", 32'(mem_req), 0);
        check_val("rst_error", 32'(error), 0);
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // Reset in the middle of the idx 7 write.
        pulse_start();
        for (int i = 0; i < 100 && !(mem_req && mem_addr == 32'h41C); i++) step();
        check_val("t1_reach_idx7", mem_addr, 32'h41C);
        rst_n = 1'b0;
        #1;
        check_val("t1_cnt_sel", 32'(cnt_sel), 0);
        check_val("t1_freeze", 32'(freeze), 0);
        check_val("t1_mem_req", 32'(mem_req), 0);
        check_val("t1_mem_addr", mem_addr, 0);
        check_val("t1_mem_wdata", mem_wdata, 0);
        check_val("t1_busy", 32'(busy), 0);
        check_val("t1_done", 32'(done), 0);
        check_val("t1_error", 32'(error), 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        check_val("t1_idle_busy", 32'(busy), 0);
        check_val("t1_idle_req", 32'(mem_req), 0);

        // Full dump, ack tied high.
        snap();
        pulse_start();
        wait_done(400);
        check_val("t2_done_lat", 32'(ncyc - start_cyc), 32'(DONE_LAT));
        check_val("t2_error_at_done", 32'(error), 0);
        repeat (3) step();
        check_val("t2_writes", 32'(wcnt - w_base), 32'(N_WRITES));
        check_val("t2_done_pulses", 32'(done_cnt - d_base), 1);
        check_val("t2_freeze_cycles", 32'(frz_cnt - f_base), 32'(DONE_LAT));
        check_val("t2_busy_after", 32'(busy), 0);
        for (int i = 0; i < 26; i++) begin
            check_val($sformatf("t2_addr%0d", i), w_addr[w_base + i], 32'h400 + 32'(4 * i));
            check_val($sformatf("t2_data%0d", i), w_data[w_base + i], 32'(16 * i));
        end
`ifdef PMC_DUMP_CHECKSUM_EN
        ck_exp = 32'h0;
        for (int i = 0; i < 26; i++) ck_exp = ck_exp ^ 32'(16 * i);
        check_val("t2_ck_addr", w_addr[w_base + 26], 32'h468);
        check_val("t2_ck_data", w_data[w_base + 26], ck_exp);
`endif

        // Ack held off three cycles on idx 5.
        ack_mode = 2;
        step();
        snap();
        pulse_start();
        wait_done(400);
        check_val("t3_done_lat", 32'(ncyc - start_cyc), 32'(DONE_LAT + 3));
        repeat (3) step();
        check_val("t3_hold_cycles", 32'(hold_cnt - h_base), 4);
        check_val("t3_writes", 32'(wcnt - w_base), 32'(N_WRITES));
        check_val("t3_addr5", w_addr[w_base + 5], 32'h414);
        check_val("t3_data5", w_data[w_base + 5], 32'h50);
        check_val("t3_freeze_cycles", 32'(frz_cnt - f_base), 32'(DONE_LAT + 3));

        // No ack at all: timeout abort at idx 0.
        ack_mode = 0;
        repeat (2) step();
        snap();
        pulse_start();
        wait_done(600);
        check_val("t4_done_lat", 32'(ncyc - start_cyc), 32'd258);
        check_val("t4_error", 32'(error), 1);
        step();
        check_val("t4_busy_next", 32'(busy), 0);
        check_val("t4_error_sticky", 32'(error), 1);
        check_val("t4_writes", 32'(wcnt - w_base), 0);
        ack_mode = 1;
        repeat (2) step();
        pulse_start();
        check_val("t4_error_cleared", 32'(error), 0);
        wait_done(400);
        repeat (3) step();

        // start re-pulsed during a dump is ignored.
        snap();
        pulse_start();
        while (ncyc - start_cyc < 5) step();
        start = 1'b1;
        step();
        start = 1'b0;
        while (ncyc - start_cyc < 40) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(400);
        check_val("t5_done_lat", 32'(ncyc - start_cyc), 32'(DONE_LAT));
        repeat (5) step();
        check_val("t5_writes", 32'(wcnt - w_base), 32'(N_WRITES));
        check_val("t5_done_pulses", 32'(done_cnt - d_base), 1);
        check_val("t5_busy_after", 32'(busy), 0);

`ifdef PMC_DUMP_CHECKSUM_EN
        // Checksum of sparse values.
        for (int i = 0; i < 32; i++) bank[i] = 32'h0;
        bank[0] = 32'h1;
        bank[1] = 32'h2;
        bank[2] = 32'h4;
        snap();
        pulse_start();
        wait_done(400);
        check_val("t6_done_lat", 32'(ncyc - start_cyc), 32'd80);
        repeat (3) step();
        check_val("t6_writes", 32'(wcnt - w_base), 32'd27);
        check_val("t6_ck_addr", w_addr[w_base + 26], 32'h468);
        check_val("t6_ck_data", w_data[w_base + 26], 32'h7);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
